// File: rtl/complex_operand_packer_if.sv
// Streaming element input and wide operand-vector output of the complex operand packer.
interface complex_operand_packer_if #(
    parameter int SIZE = 16,
    parameter int DW   = 64
);
    localparam int LW = $clog2(SIZE) + 1;

    logic [1:0][DW-1:0]        a_i;
    logic [1:0][DW-1:0]        b_i;
    logic                      last_i;
    logic                      sub_i;
    logic                      in_valid_i;
    logic                      in_ready_o;
    logic                      flush_i;
    logic [SIZE*4-1:0][DW-1:0] operands_o;
    logic                      sub_o;
    logic [LW-1:0]             len_o;
    logic                      out_valid_o;
    logic                      out_ready_i;
    logic                      busy_o;

    modport master (
        output a_i, b_i, last_i, sub_i, in_valid_i, flush_i, out_ready_i,
        input  in_ready_o, operands_o, sub_o, len_o, out_valid_o, busy_o
    );

    modport slave (
        input  a_i, b_i, last_i, sub_i, in_valid_i, flush_i, out_ready_i,
        output in_ready_o, operands_o, sub_o, len_o, out_valid_o, busy_o
    );
endinterface

// File: rtl/complex_operand_packer.sv
// Packs up to SIZE complex (a,b) beats into ping-pong vector buffers; vector valid one cycle after completion.
// in_ready drops only when the fill buffer is still full; out_valid holds until out_ready.
module complex_operand_packer #(
    parameter int SIZE = 16,
    parameter int DW   = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    complex_operand_packer_if.slave  bus
);
    localparam int LW = $clog2(SIZE) + 1;
    localparam int IW = $clog2(SIZE);

    typedef logic [3:0][DW-1:0] lane_t;

    lane_t         buf_q [2][SIZE];
    logic [1:0]    sub_buf_q;
    logic [LW-1:0] len_q [2];

    logic [1:0]    full_q,   full_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [IW-1:0] idx_q,    idx_d;

    logic accept;
    logic complete;
    logic drain;

    // Beats arriving alongside a flush are discarded with the rest of the state.
    assign accept   = bus.in_valid_i & bus.in_ready_o & ~bus.flush_i;
    assign complete = accept & (bus.last_i | (idx_q == IW'(SIZE - 1)));
    assign drain    = bus.out_valid_o & bus.out_ready_i;

    always_comb begin
        full_d   = full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        idx_d    = idx_q;
        if (drain) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
        end
        if (accept) begin
            idx_d = idx_q + IW'(1);
        end
        if (complete) begin
            full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = ~wr_ptr_q;
            idx_d            = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i | bus.flush_i) begin
            full_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            idx_q    <= idx_d;
        end
    end

    // Payload storage needs no reset: it is only observed behind full_q and the len mask.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            buf_q[wr_ptr_q][idx_q] <= {bus.b_i[1], bus.b_i[0], bus.a_i[1], bus.a_i[0]};
            if (idx_q == '0) begin
                sub_buf_q[wr_ptr_q] <= bus.sub_i;
            end
            if (complete) begin
                len_q[wr_ptr_q] <= LW'(idx_q) + LW'(1);
            end
        end
    end

    assign bus.in_ready_o  = ~rst_i & ~full_q[wr_ptr_q];
    assign bus.out_valid_o = full_q[rd_ptr_q];
    assign bus.sub_o       = sub_buf_q[rd_ptr_q];
    assign bus.len_o       = len_q[rd_ptr_q];
    assign bus.busy_o      = (|full_q) | (idx_q != '0);

    // Stale lanes past len from an earlier, longer vector are masked to zero.
    always_comb begin
        bus.operands_o = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (LW'(i) < len_q[rd_ptr_q]) begin
                bus.operands_o[4*i +: 4] = buf_q[rd_ptr_q][i];
            end
        end
    end
endmodule

// File: tb/tb_complex_operand_packer.sv
module tb_complex_operand_packer;
    localparam int SIZE = 16;
    localparam int DW   = 64;

    typedef logic [SIZE*4-1:0][DW-1:0] ops_t;
    typedef logic [1:0][DW-1:0]        elem_t;
    typedef struct {
        ops_t ops;
        logic sub;
        int   len;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    complex_operand_packer_if #(.SIZE(SIZE), .DW(DW)) ifc();
    complex_operand_packer #(.SIZE(SIZE), .DW(DW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc)
    );

    initial forever #5 clk = ~clk;

    int n_cmp    = 0;
    int n_fail   = 0;
    int phase    = 0;
    int rdy_mode = 0;   // 0 hold low, 1 hold high, 2 random
    bit end_req  = 1'b0;
    bit end_ack  = 1'b0;

    // ---------------- reference model + compare (sole checker) ----------------
    vec_t exp_q[$];
    ops_t cur_ops = '0;
    logic cur_sub = 1'b0;
    int   cur_idx = 0;
    int   cyc = 0, last_hs_cyc = 0, last_phase = 0;
    int   pops_in_phase = 0, acc_in_phase = 0;
    bit   lit_done = 1'b0, lit3_done = 1'b0, flush_seen = 1'b0, after_flush = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic int pops_expected(int ph);
        case (ph)
            1: return 1;
            2: return 1;
            3: return 3;
            4: return 1;
            6: return 1000;
            default: return 0;
        endcase
    endfunction

    initial begin
        vec_t v;
        logic [63:0] pad;
        forever begin
            @(negedge clk);
            cyc++;
            if (phase != last_phase) begin
                chk($sformatf("phase%0d_vectors", last_phase), 64'(pops_in_phase),
                    64'(pops_expected(last_phase)));
                last_phase    = phase;
                pops_in_phase = 0;
                acc_in_phase  = 0;
                lit_done      = 1'b0;
                lit3_done     = 1'b0;
                after_flush   = 1'b0;
            end

            chk("in_ready", 64'(ifc.in_ready_o), 64'(!rst && (exp_q.size() < 2)));
            chk("out_valid", 64'(ifc.out_valid_o), 64'(exp_q.size() > 0));
            chk("busy", 64'(ifc.busy_o), 64'((exp_q.size() > 0) || (cur_idx != 0)));

            if (ifc.out_valid_o === 1'b1 && exp_q.size() > 0) begin
                chk("len", 64'(ifc.len_o), 64'(exp_q[0].len));
                chk("sub", 64'(ifc.sub_o), 64'(exp_q[0].sub));
                n_cmp++;
                if (ifc.operands_o !== exp_q[0].ops) begin
                    n_fail++;
                    for (int j = 0; j < SIZE*4; j++) begin
                        if (ifc.operands_o[j] !== exp_q[0].ops[j]) begin
                            $display("FAIL operands: scalar %0d got %h expected %h",
                                     j, ifc.operands_o[j], exp_q[0].ops[j]);
                            break;
                        end
                    end
                end
            end

            // Hand-computed expectations for the directed scenarios.
            if (phase == 1 && ifc.out_valid_o === 1'b1 && !lit_done) begin
                lit_done = 1'b1;
                chk("p1_latency", 64'(cyc - last_hs_cyc), 64'd1);
                chk("p1_len", 64'(ifc.len_o), 64'd16);
                chk("p1_lane1_are", ifc.operands_o[4], 64'h3FF0000000000000);
                chk("p1_lane1_aim", ifc.operands_o[5], 64'h3FF8000000000000);
                chk("p1_lane1_bre", ifc.operands_o[6], 64'h4000000000000000);
                chk("p1_lane1_bim", ifc.operands_o[7], 64'hBFF0000000000000);
                chk("p1_lane15_are", ifc.operands_o[60], 64'h402E000000000000);
            end
            if (phase == 2 && ifc.out_valid_o === 1'b1 && !lit_done) begin
                lit_done = 1'b1;
                pad = '0;
                for (int j = 20; j < SIZE*4; j++) pad |= ifc.operands_o[j];
                chk("p2_len", 64'(ifc.len_o), 64'd5);
                chk("p2_sub", 64'(ifc.sub_o), 64'd1);
                chk("p2_padding", pad, 64'd0);
            end
            if (phase == 3 && !rst && ifc.in_ready_o === 1'b0 && !lit3_done) begin
                lit3_done = 1'b1;
                chk("p3_beats_before_stall", 64'(acc_in_phase), 64'd32);
            end
            if (phase == 4 && ifc.flush_i === 1'b1) begin
                chk("p4_pending_at_flush", 64'(ifc.out_valid_o), 64'd1);
            end
            if (flush_seen) begin
                chk("p4_valid_after_flush", 64'(ifc.out_valid_o), 64'd0);
                chk("p4_busy_after_flush", 64'(ifc.busy_o), 64'd0);
            end
            if (phase == 4 && after_flush && ifc.out_valid_o === 1'b1 && !lit_done) begin
                lit_done = 1'b1;
                chk("p4_len_after_flush", 64'(ifc.len_o), 64'd16);
            end
            flush_seen = (ifc.flush_i === 1'b1) && !rst;

            // Advance the model by what the coming edge commits.
            if (rst || ifc.flush_i) begin
                exp_q.delete();
                cur_idx = 0;
                cur_ops = '0;
                if (ifc.flush_i) after_flush = 1'b1;
            end else begin
                if (ifc.out_valid_o && ifc.out_ready_i && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    pops_in_phase++;
                end
                if (ifc.in_valid_i && ifc.in_ready_o) begin
                    cur_ops[4*cur_idx]     = ifc.a_i[0];
                    cur_ops[4*cur_idx + 1] = ifc.a_i[1];
                    cur_ops[4*cur_idx + 2] = ifc.b_i[0];
                    cur_ops[4*cur_idx + 3] = ifc.b_i[1];
                    if (cur_idx == 0) cur_sub = ifc.sub_i;
                    cur_idx++;
                    acc_in_phase++;
                    if (ifc.last_i || cur_idx == SIZE) begin
                        v.ops = cur_ops;
                        v.sub = cur_sub;
                        v.len = cur_idx;
                        exp_q.push_back(v);
                        cur_idx = 0;
                        cur_ops = '0;
                        last_hs_cyc = cyc;
                    end
                end
            end

            if (end_req && !end_ack) begin
                chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
                end_ack = 1'b1;
            end
        end
    end

    // ---------------- downstream ready generator ----------------
    initial begin
        ifc.out_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       ifc.out_ready_i = 1'b0;
                1:       ifc.out_ready_i = 1'b1;
                default: ifc.out_ready_i = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // ---------------- stimulus ----------------
    function automatic elem_t rnd_elem();
        elem_t e;
        e[0] = {$urandom, $urandom};
        e[1] = {$urandom, $urandom};
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic beat(input elem_t a, input elem_t b, input logic last, input logic sub);
        bit done;
        int w;
        done = 1'b0;
        w    = 0;
        ifc.a_i = a;  ifc.b_i = b;  ifc.last_i = last;  ifc.sub_i = sub;
        ifc.in_valid_i = 1'b1;
        while (!done) begin
            @(negedge clk);
            done = (ifc.in_ready_o === 1'b1);
            @(posedge clk);
            #1;
            w++;
            if (!done && w > 500) begin
                $display("FAIL beat_timeout: in_ready low for %0d cycles, required accept", w);
                $fatal(1);
            end
        end
        ifc.in_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        forever begin
            @(negedge clk);
            if (ifc.busy_o === 1'b0 && ifc.out_valid_o === 1'b0) break;
            w++;
            if (w > 500) begin
                $display("FAIL idle_timeout: busy %b out_valid %b, required 0 0",
                         ifc.busy_o, ifc.out_valid_o);
                $fatal(1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int len;
        int w;
        elem_t a, b;
        ifc.a_i = '0;  ifc.b_i = '0;  ifc.last_i = 1'b0;  ifc.sub_i = 1'b0;
        ifc.in_valid_i = 1'b0;  ifc.flush_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        phase = 1;  rdy_mode = 1;
        for (int k = 0; k < 16; k++) begin
            a[0] = $realtobits(real'(k));        a[1] = $realtobits(real'(k) + 0.5);
            b[0] = $realtobits(2.0 * real'(k));  b[1] = $realtobits(-real'(k));
            beat(a, b, k == 15, 1'b0);
        end
        wait_idle();

        phase = 2;
        for (int k = 0; k < 5; k++) beat(rnd_elem(), rnd_elem(), k == 4, k == 0);
        wait_idle();

        phase = 3;  rdy_mode = 0;
        for (int k = 0; k < 32; k++) beat(rnd_elem(), rnd_elem(), 1'b0, 1'($urandom));
        a = rnd_elem();  b = rnd_elem();
        ifc.a_i = a;  ifc.b_i = b;  ifc.last_i = 1'b0;  ifc.in_valid_i = 1'b1;
        repeat (8) @(posedge clk);
        #1 rdy_mode = 1;
        beat(a, b, 1'b0, 1'b0);
        for (int k = 33; k < 40; k++) beat(rnd_elem(), rnd_elem(), k == 39, 1'($urandom));
        wait_idle();

        phase = 4;  rdy_mode = 0;
        for (int k = 0; k < 23; k++) beat(rnd_elem(), rnd_elem(), k == 15, 1'b1);
        ifc.a_i = rnd_elem();  ifc.b_i = rnd_elem();
        ifc.flush_i = 1'b1;  ifc.in_valid_i = 1'b1;
        @(posedge clk);
        #1 ifc.flush_i = 1'b0;  ifc.in_valid_i = 1'b0;  rdy_mode = 1;
        for (int k = 0; k < 16; k++) beat(rnd_elem(), rnd_elem(), 1'b0, 1'b0);
        wait_idle();

        phase = 5;  rdy_mode = 0;
        for (int k = 0; k < 20; k++) beat(rnd_elem(), rnd_elem(), 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;  rdy_mode = 1;
        wait_idle();

        phase = 6;  rdy_mode = 2;
        for (int v = 0; v < 1000; v++) begin
            len = $urandom_range(1, SIZE);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                beat(rnd_elem(), rnd_elem(),
                     (k == len - 1) ? ((len == SIZE) ? 1'($urandom) : 1'b1) : 1'b0,
                     1'($urandom));
            end
        end
        rdy_mode = 1;
        wait_idle();

        phase = 7;
        end_req = 1'b1;
        w = 0;
        while (!end_ack) begin
            @(posedge clk);
            w++;
            if (w > 10) begin
                $display("FAIL end_handshake: no final check after %0d cycles", w);
                $fatal(1);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
